tx_packetizer: RTL

TX_PACKETIZER -- requirements
Module: tx_packetizer

---
 rtl/tx_packetizer.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/tx_packetizer.sv
// tx_packetizer: stores up to 256 16-bit samples and, on request, streams a
// framed packet over an 8N1 UART line:
//   55 AA ct fsa_lo fsa_hi lsa_lo lsa_hi {buf[k]_lo buf[k]_hi} k = 0..ct-1
// Bytes go out back-to-back with no idle time between them.
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data - sample buffer write port (ignored while busy)
//   start, ct, fsa, lsa - packet request and the header fields it latches
//   serial              - UART line, idle high
//   busy                - packet in progress
//   tx_done             - one-cycle pulse after the last stop bit
module tx_packetizer #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [7:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        start,
    input  logic [7:0]  ct,
    input  logic [15:0] fsa,
    input  logic [15:0] lsa,
    output logic        serial,
    output logic        busy,
    output logic        tx_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // byte-level states
    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] HDR0  = 4'd1;
    localparam logic [3:0] HDR1  = 4'd2;
    localparam logic [3:0] CT    = 4'd3;
    localparam logic [3:0] FSA_L = 4'd4;
    localparam logic [3:0] FSA_H = 4'd5;
    localparam logic [3:0] LSA_L = 4'd6;
    localparam logic [3:0] LSA_H = 4'd7;
    localparam logic [3:0] SMP_L = 4'd8;
    localparam logic [3:0] SMP_H = 4'd9;
    localparam logic [3:0] DONE  = 4'd10;

    // bit-level states
    localparam logic [1:0] BIT_IDLE  = 2'd0;
    localparam logic [1:0] START_BIT = 2'd1;
    localparam logic [1:0] DATA_BITS = 2'd2;
    localparam logic [1:0] STOP_BIT  = 2'd3;

    logic [15:0]      mem [256];
    logic [15:0]      rd_data;
    logic [7:0]       rd_addr;

    logic [3:0]       byte_state, byte_state_n;
    logic [1:0]       bit_state,  bit_state_n;
    logic [CNT_W-1:0] clk_cnt,    clk_cnt_n;
    logic [2:0]       bit_cnt,    bit_cnt_n;
    logic [7:0]       shreg,      shreg_n;
    logic [7:0]       index,      index_n;
    logic [7:0]       ct_q,       ct_q_n;
    logic [15:0]      fsa_q,      fsa_q_n;
    logic [15:0]      lsa_q,      lsa_q_n;
    logic             serial_n, busy_n, tx_done_n;

    logic             accept;
    logic             bit_last;
    logic             byte_end;
    logic             load;
    logic             finish;
    logic [7:0]       load_byte;
    logic [7:0]       ct_last;

    assign accept   = start && !busy && (ct != 8'd0);
    assign bit_last = (clk_cnt == CNT_LAST);
    assign ct_last  = 8'(ct_q - 8'd1);

    // While the high byte of sample k is on the line, prefetch sample k+1 so
    // the next low byte is already registered when the stop bit ends.
    assign rd_addr = (byte_state == SMP_H) ? 8'(index + 8'd1) : index;

    // Sample buffer: write only while idle, one-cycle registered read.
    always_ff @(posedge clk) begin
        if (!reset && wr_en && !busy) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_state <= IDLE;
            bit_state  <= BIT_IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            index      <= '0;
            ct_q       <= '0;
            fsa_q      <= '0;
            lsa_q      <= '0;
            serial     <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            byte_state <= byte_state_n;
            bit_state  <= bit_state_n;
            clk_cnt    <= clk_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            index      <= index_n;
            ct_q       <= ct_q_n;
            fsa_q      <= fsa_q_n;
            lsa_q      <= lsa_q_n;
            serial     <= serial_n;
            busy       <= busy_n;
            tx_done    <= tx_done_n;
        end
    end

    // Next-state logic for both FSMs.
    always_comb begin
        byte_state_n = byte_state;
        bit_state_n  = bit_state;
        clk_cnt_n    = clk_cnt;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        index_n      = index;
        ct_q_n       = ct_q;
        fsa_q_n      = fsa_q;
        lsa_q_n      = lsa_q;
        busy_n       = busy;
        tx_done_n    = 1'b0;
        byte_end     = 1'b0;
        load         = 1'b0;
        finish       = 1'b0;
        load_byte    = 8'h00;
        serial_n     = 1'b1;

        // bit timing
        case (bit_state)
            START_BIT: begin
                if (bit_last) begin
                    clk_cnt_n   = '0;
                    bit_cnt_n   = '0;
                    bit_state_n = DATA_BITS;
                end else begin
                    clk_cnt_n = CNT_W'(clk_cnt + 1'b1);
                end
            end
            DATA_BITS: begin
                if (bit_last) begin
                    clk_cnt_n = '0;
                    shreg_n   = {1'b0, shreg[7:1]};
                    if (bit_cnt == 3'd7) begin
                        bit_state_n = STOP_BIT;
                    end else begin
                        bit_cnt_n = 3'(bit_cnt + 3'd1);
                    end
                end else begin
                    clk_cnt_n = CNT_W'(clk_cnt + 1'b1);
                end
            end
            STOP_BIT: begin
                if (bit_last) begin
                    clk_cnt_n = '0;
                    byte_end  = 1'b1;
                end else begin
                    clk_cnt_n = CNT_W'(clk_cnt + 1'b1);
                end
            end
            default: ;
        endcase

        // byte sequencing: the next byte is loaded on the last stop-bit cycle
        case (byte_state)
            IDLE, DONE: begin
                byte_state_n = IDLE;
                if (accept) begin
                    ct_q_n       = ct;
                    fsa_q_n      = fsa;
                    lsa_q_n      = lsa;
                    index_n      = '0;
                    byte_state_n = HDR0;
                    load         = 1'b1;
                    load_byte    = 8'h55;
                end
            end
            HDR0:  if (byte_end) begin byte_state_n = HDR1;  load = 1'b1; load_byte = 8'hAA;        end
            HDR1:  if (byte_end) begin byte_state_n = CT;    load = 1'b1; load_byte = ct_q;         end
            CT:    if (byte_end) begin byte_state_n = FSA_L; load = 1'b1; load_byte = fsa_q[7:0];   end
            FSA_L: if (byte_end) begin byte_state_n = FSA_H; load = 1'b1; load_byte = fsa_q[15:8];  end
            FSA_H: if (byte_end) begin byte_state_n = LSA_L; load = 1'b1; load_byte = lsa_q[7:0];   end
            LSA_L: if (byte_end) begin byte_state_n = LSA_H; load = 1'b1; load_byte = lsa_q[15:8];  end
            LSA_H: if (byte_end) begin byte_state_n = SMP_L; load = 1'b1; load_byte = rd_data[7:0]; end
            SMP_L: if (byte_end) begin byte_state_n = SMP_H; load = 1'b1; load_byte = rd_data[15:8]; end
            SMP_H: begin
                if (byte_end) begin
                    if (index != ct_last) begin
                        byte_state_n = SMP_L;
                        index_n      = 8'(index + 8'd1);
                        load         = 1'b1;
                        load_byte    = rd_data[7:0];
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            default: byte_state_n = IDLE;
        endcase

        if (load) begin
            bit_state_n = START_BIT;
            clk_cnt_n   = '0;
            bit_cnt_n   = '0;
            shreg_n     = load_byte;
            busy_n      = 1'b1;
        end

        if (finish) begin
            bit_state_n  = BIT_IDLE;
            byte_state_n = DONE;
            index_n      = '0;
            busy_n       = 1'b0;
            tx_done_n    = 1'b1;
        end

        // line level follows the bit state being entered
        case (bit_state_n)
            START_BIT: serial_n = 1'b0;
            DATA_BITS: serial_n = shreg_n[0];
            default:   serial_n = 1'b1;
        endcase
    end

endmodule
